muntjac_fetch_redirect_ctrl: RTL and testbench
==============================================

// Module: muntjac_fetch_redirect_ctrl
// PURPOSE
// - Sequences every frontend redirect into the instruction fetcher's one-cycle (pc, branch_info, reason, valid) input.
// - Redirect sources: trap/xret (CSR), branch mispredict (execute), fence.i / sfence.vma (commit).
// - Sits between backend and fetcher. Registers the chosen redirect.
// - Serialises fences: waits for store-buffer drain plus a settle window, then issues the flush redirect.
// PARAMETERS
// - XLEN         64  address width
// - SettleCycles 2   cycles sb_empty_i must stay high before a fence redirect issues (1..15)
// PORTS
// - clk_i                   in   1     clock; single clock domain
// - rst_i                   in   1     reset, synchronous, active-high
// - trap_valid_i            in   1     trap/xret redirect pulse
// - trap_pc_i               in   XLEN  trap/xret target
// - trap_reason_i           in   if_reason_e  IF_PROT_CHANGED etc., supplied by CSR unit
// - mispredict_valid_i      in   1     branch mispredict pulse
// - mispredict_pc_i         in   XLEN  corrected target
// - mispredict_info_i       in   branch_info_t  resolved branch, forwarded for BTB/BHT/RAS training
// - fence_valid_i           in   1     fence.i / sfence.vma reached commit
// - fence_kind_i            in   fence_kind_e   FENCE_KIND_I / FENCE_KIND_VMA
// - fence_npc_i             in   XLEN  pc of instruction after the fence
// - sb_empty_i              in   1     store buffer drained
// - fence_busy_o            out  1     fence in progress; commit stalls
// - squash_o                out  1     kill younger backend instructions (same cycle as redirect_valid_o)
// - redirect_valid_o        out  1     to fetcher i_valid
// - redirect_pc_o           out  XLEN  to fetcher i_pc; bit 0 always 0
// - redirect_reason_o       out  if_reason_e   to fetcher i_reason
// - redirect_branch_info_o  out  branch_info_t to fetcher i_branch_info
// BEHAVIOUR
// - Reset: FSM=IDLE, settle counter=0. All outputs 0; redirect_branch_info_o.branch_type=BRANCH_NONE.
// - redirect_valid_o / squash_o are single-cycle pulses. The fetcher has no ready; every pulse is consumed.
// - Trap and mispredict latency: 1 cycle (input cycle N -> redirect_valid_o cycle N+1).
// - Priority in any cycle: trap > fence > mispredict. Losers are dropped, not queued (they are younger, wrong-path).
// - branch_info output is mispredict_info_i only for a mispredict redirect, else branch_type=BRANCH_NONE.
// - FSM IDLE:
//   - trap -> issue trap redirect, stay IDLE.
//   - fence_valid_i -> DRAIN, fence_busy_o=1 from next cycle; latch kind and npc.
//   - else mispredict -> issue IF_MISPREDICT redirect.
// - FSM DRAIN: fence_busy_o=1; counter +1 while sb_empty_i, cleared to 0 when sb_empty_i=0.
//   - Counter reaches SettleCycles -> ISSUE.
// - FSM ISSUE (1 cycle): redirect_valid_o=1 (registered out next cycle), pc=latched npc.
//   - reason: IF_FENCE_I for FENCE_KIND_I, IF_SATP_CHANGED for FENCE_KIND_VMA.
//   - -> IDLE; fence_busy_o falls with the redirect pulse.
// - DRAIN/ISSUE + trap_valid_i: fence aborted, trap redirect issued, -> IDLE, counter cleared.
// - DRAIN/ISSUE + mispredict_valid_i or fence_valid_i: ignored.
// - sb_empty_i already high on fence entry: ISSUE after exactly SettleCycles cycles in DRAIN.
// - Minimum fence latency: fence_valid_i cycle N -> redirect_valid_o at N+SettleCycles+2.
// - rst_i mid-fence: returns to IDLE next edge, no redirect emitted.
// - Assertions: at most one redirect per cycle; fence_busy_o never 1 in IDLE; SettleCycles in range.
// STRUCTURE
// - muntjac_pkg gains: fence_kind_e {FENCE_KIND_I, FENCE_KIND_VMA} and fetch_redirect_state_e {IDLE, DRAIN, ISSUE}.
// - Reuses if_reason_e and branch_info_t unchanged.
// - Single module, no sub-modules.
// - Output stage is one register bank {valid, pc, reason, info, squash}.
// TESTING
// - trap_valid_i=1, pc=0x8000_0001, reason IF_PROT_CHANGED ->
//   next cycle redirect pc=0x8000_0000 and reason IF_PROT_CHANGED, one-cycle pulse with squash_o.
// - mispredict pc=0x1234, info.branch_type=BRANCH_TAKEN ->
//   next cycle redirect reason IF_MISPREDICT with info forwarded. Trap in same cycle -> trap only.
// - fence.i at cycle 0, npc=0x2000, sb_empty_i=1, SettleCycles=2 ->
//   fence_busy_o cycles 1-3, redirect pc=0x2000 and reason IF_FENCE_I at cycle 4.
// - sfence.vma with sb_empty_i low 5 cycles, then high, one-cycle glitch low mid-settle ->
//   counter restarts, redirect reason IF_SATP_CHANGED after full settle.
// - trap during DRAIN -> trap redirect only, no later fence redirect.
//   Mispredict during DRAIN -> nothing emitted.
// - rst_i asserted in DRAIN -> all outputs 0 next cycle. Fence issued after reset completes normally.

Source files
------------

// File: rtl/muntjac_pkg.sv
// Shared frontend types used by the fetch redirect controller and the fetcher.
// Holds the redirect reason encoding, branch training info, fence kinds and
// the redirect controller state encoding.
package muntjac_pkg;

  typedef enum logic [3:0] {
    IF_PREFETCH     = 4'b0000,
    IF_PREDICT      = 4'b0001,
    IF_MISPREDICT   = 4'b0011,
    IF_PROT_CHANGED = 4'b1000,
    IF_FENCE_I      = 4'b1010,
    IF_SATP_CHANGED = 4'b1100
  } if_reason_e;

  typedef enum logic [2:0] {
    BRANCH_NONE    = 3'd0,
    BRANCH_JAL     = 3'd1,
    BRANCH_JALR    = 3'd2,
    BRANCH_CALL    = 3'd3,
    BRANCH_RET     = 3'd4,
    BRANCH_YIELD   = 3'd5,
    BRANCH_UNTAKEN = 3'd6,
    BRANCH_TAKEN   = 3'd7
  } branch_type_e;

  typedef struct packed {
    branch_type_e branch_type;
    logic [63:0]  pc;
    logic         compressed;
  } branch_info_t;

  typedef enum logic {
    FENCE_KIND_I   = 1'b0,
    FENCE_KIND_VMA = 1'b1
  } fence_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } fetch_redirect_state_e;

endpackage

// File: rtl/muntjac_fetch_redirect_ctrl.sv
// Frontend redirect sequencer. Arbitrates trap/xret, branch mispredict and
// fence.i / sfence.vma redirects into the fetcher's single-cycle redirect input.
// Fences wait for the store buffer to drain and stay drained for SettleCycles
// before the flush redirect is issued.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no fence pending; trap and mispredict redirects pass through
// DRAIN | fence latched; counting consecutive cycles with sb_empty_i high
// ISSUE | settle window met; fence redirect generated this cycle
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   trap_*                     trap/xret redirect request (highest priority)
//   mispredict_*               branch mispredict redirect (lowest priority)
//   fence_*                    fence.i / sfence.vma reached commit
//   sb_empty_i                 store buffer drained
//   fence_busy_o               fence in progress, commit stalls
//   squash_o                   kill younger backend instructions
//   redirect_*_o               registered redirect to the fetcher
module muntjac_fetch_redirect_ctrl
  import muntjac_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned SettleCycles = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  if_reason_e        trap_reason_i,
  input  logic              mispredict_valid_i,
  input  logic [XLEN-1:0]   mispredict_pc_i,
  input  branch_info_t      mispredict_info_i,
  input  logic              fence_valid_i,
  input  fence_kind_e       fence_kind_i,
  input  logic [XLEN-1:0]   fence_npc_i,
  input  logic              sb_empty_i,
  output logic              fence_busy_o,
  output logic              squash_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output if_reason_e        redirect_reason_o,
  output branch_info_t      redirect_branch_info_o
);

  if (SettleCycles < 1 || SettleCycles > 15) begin : g_bad_settle
    $error("SettleCycles must be within 1..15");
  end

  localparam logic [3:0] SettleCnt = 4'(SettleCycles);

  fetch_redirect_state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            cnt_inc;
  fence_kind_e           kind_q, kind_d;
  logic [XLEN-1:0]       npc_q, npc_d;

  logic                  sel_trap, sel_fence, sel_misp;
  logic                  valid_d;
  logic [XLEN-1:0]       pc_d;
  if_reason_e            reason_d;
  branch_info_t          info_d;

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    npc_d     = npc_q;
    sel_trap  = 1'b0;
    sel_fence = 1'b0;
    sel_misp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trap_valid_i) begin
          sel_trap = 1'b1;
        end else if (fence_valid_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
          kind_d  = fence_kind_i;
          npc_d   = fence_npc_i;
        end else if (mispredict_valid_i) begin
          sel_misp = 1'b1;
        end
      end
      DRAIN: begin
        if (trap_valid_i) begin
          sel_trap = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (!sb_empty_i) begin
          // Any refill of the store buffer restarts the settle window.
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == SettleCnt) state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A trap here is older than the fence redirect, so the fence is dropped.
        if (trap_valid_i) sel_trap  = 1'b1;
        else              sel_fence = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d            = sel_trap | sel_fence | sel_misp;
    pc_d               = '0;
    reason_d           = IF_PREFETCH;
    info_d             = '0;
    info_d.branch_type = BRANCH_NONE;
    if (sel_trap) begin
      pc_d     = trap_pc_i;
      reason_d = trap_reason_i;
    end else if (sel_fence) begin
      pc_d     = npc_q;
      reason_d = (kind_q == FENCE_KIND_I) ? IF_FENCE_I : IF_SATP_CHANGED;
    end else if (sel_misp) begin
      pc_d     = mispredict_pc_i;
      reason_d = IF_MISPREDICT;
      info_d   = mispredict_info_i;
    end
    // Fetch targets are at least halfword aligned.
    pc_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q                <= IDLE;
      cnt_q                  <= '0;
      kind_q                 <= FENCE_KIND_I;
      npc_q                  <= '0;
      redirect_valid_o       <= 1'b0;
      squash_o               <= 1'b0;
      redirect_pc_o          <= '0;
      redirect_reason_o      <= IF_PREFETCH;
      redirect_branch_info_o <= '0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      kind_q                 <= kind_d;
      npc_q                  <= npc_d;
      redirect_valid_o       <= valid_d;
      squash_o               <= valid_d;
      redirect_pc_o          <= pc_d;
      redirect_reason_o      <= reason_d;
      redirect_branch_info_o <= info_d;
    end
  end

  assign fence_busy_o = (state_q != IDLE);

  a_one_redirect : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({sel_trap, sel_fence, sel_misp}));

  a_busy_not_idle : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == IDLE) |-> !fence_busy_o);

endmodule

// File: tb/tb_muntjac_fetch_redirect_ctrl.sv
module tb_muntjac_fetch_redirect_ctrl;
  import muntjac_pkg::*;

  localparam int unsigned XLEN = 64;

  logic              clk;
  logic              rst;
  logic              trap_valid;
  logic [XLEN-1:0]   trap_pc;
  if_reason_e        trap_reason;
  logic              mispredict_valid;
  logic [XLEN-1:0]   mispredict_pc;
  branch_info_t      mispredict_info;
  logic              fence_valid;
  fence_kind_e       fence_kind;
  logic [XLEN-1:0]   fence_npc;
  logic              sb_empty;
  logic              fence_busy;
  logic              squash;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  if_reason_e        redirect_reason;
  branch_info_t      redirect_info;

  muntjac_fetch_redirect_ctrl #(.XLEN(XLEN), .SettleCycles(2)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .trap_valid_i           (trap_valid),
    .trap_pc_i              (trap_pc),
    .trap_reason_i          (trap_reason),
    .mispredict_valid_i     (mispredict_valid),
    .mispredict_pc_i        (mispredict_pc),
    .mispredict_info_i      (mispredict_info),
    .fence_valid_i          (fence_valid),
    .fence_kind_i           (fence_kind),
    .fence_npc_i            (fence_npc),
    .sb_empty_i             (sb_empty),
    .fence_busy_o           (fence_busy),
    .squash_o               (squash),
    .redirect_valid_o       (redirect_valid),
    .redirect_pc_o          (redirect_pc),
    .redirect_reason_o      (redirect_reason),
    .redirect_branch_info_o (redirect_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cycle;
    logic [63:0]  pc;
    if_reason_e   reason;
    branch_info_t info;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic branch_info_t no_info();
    branch_info_t b;
    b = '0;
    b.branch_type = BRANCH_NONE;
    return b;
  endfunction

  function automatic void expect_redirect(input int c, input logic [63:0] pc,
                                          input if_reason_e r, input branch_info_t i);
    exp_t e;
    e.cycle = c; e.pc = pc; e.reason = r; e.info = i;
    exp_q.push_back(e);
  endfunction

  // Monitor: every redirect pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", {64'd0, redirect_pc}, 128'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("redirect_cycle", 128'(cyc), 128'(e.cycle));
        check("redirect_pc", 128'(redirect_pc), 128'(e.pc));
        check("redirect_reason", 128'(redirect_reason), 128'(e.reason));
        check("redirect_info", 128'(redirect_info), 128'(e.info));
        check("squash_with_redirect", 128'(squash), 128'd1);
      end
    end else if (squash) begin
      check("squash_without_redirect", 128'(squash), 128'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    trap_valid       = 1'b0;
    mispredict_valid = 1'b0;
    fence_valid      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    branch_info_t taken;
    int k;
    logic sb_pat [10];

    rst              = 1'b1;
    trap_valid       = 1'b0;
    trap_pc          = '0;
    trap_reason      = IF_PREFETCH;
    mispredict_valid = 1'b0;
    mispredict_pc    = '0;
    mispredict_info  = '0;
    fence_valid      = 1'b0;
    fence_kind       = FENCE_KIND_I;
    fence_npc        = '0;
    sb_empty         = 1'b1;

    ticks(3);
    check("reset_valid", 128'(redirect_valid), 128'd0);
    check("reset_squash", 128'(squash), 128'd0);
    check("reset_pc", 128'(redirect_pc), 128'd0);
    check("reset_reason", 128'(redirect_reason), 128'(IF_PREFETCH));
    check("reset_branch_type", 128'(redirect_info.branch_type), 128'(BRANCH_NONE));
    check("reset_busy", 128'(fence_busy), 128'd0);
    rst = 1'b0;
    ticks(2);

    // Trap with odd target: bit 0 cleared.
    k = cyc;
    trap_valid = 1'b1; trap_pc = 64'h8000_0001; trap_reason = IF_PROT_CHANGED;
    expect_redirect(k + 1, 64'h8000_0000, IF_PROT_CHANGED, no_info());
    ticks(3);

    // Mispredict forwards branch info.
    taken = '0;
    taken.branch_type = BRANCH_TAKEN;
    taken.pc          = 64'h1230;
    taken.compressed  = 1'b1;
    k = cyc;
    mispredict_valid = 1'b1; mispredict_pc = 64'h1234; mispredict_info = taken;
    expect_redirect(k + 1, 64'h1234, IF_MISPREDICT, taken);
    ticks(3);

    // Trap beats mispredict in the same cycle.
    k = cyc;
    trap_valid = 1'b1; trap_pc = 64'h9000; trap_reason = IF_SATP_CHANGED;
    mispredict_valid = 1'b1; mispredict_pc = 64'h1234; mispredict_info = taken;
    expect_redirect(k + 1, 64'h9000, IF_SATP_CHANGED, no_info());
    ticks(3);

    // Trap beats fence in the same cycle: fence never starts.
    k = cyc;
    trap_valid = 1'b1; trap_pc = 64'hA000; trap_reason = IF_PROT_CHANGED;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_I; fence_npc = 64'hA100;
    expect_redirect(k + 1, 64'hA000, IF_PROT_CHANGED, no_info());
    tick();
    check("trap_fence_busy", 128'(fence_busy), 128'd0);
    ticks(6);

    // fence.i with drained store buffer: busy cycles 1-3, redirect at 4.
    k = cyc;
    sb_empty = 1'b1;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_I; fence_npc = 64'h2000;
    expect_redirect(k + 4, 64'h2000, IF_FENCE_I, no_info());
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("fence_i_busy_c%0d", i), 128'(fence_busy), 128'(i <= 3));
    end
    ticks(2);

    // sfence.vma: store buffer busy, then a one-cycle glitch mid-settle.
    sb_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    k = cyc;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_VMA; fence_npc = 64'h3004;
    expect_redirect(k + 11, 64'h3004, IF_SATP_CHANGED, no_info());
    for (int i = 0; i < 10; i++) begin
      sb_empty = sb_pat[i];
      tick();
    end
    sb_empty = 1'b1;
    check("vma_busy_issue", 128'(fence_busy), 128'd1);
    tick();
    check("vma_busy_done", 128'(fence_busy), 128'd0);
    ticks(2);

    // Trap during DRAIN aborts the fence; mispredict and new fence ignored.
    k = cyc;
    sb_empty = 1'b0;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_I; fence_npc = 64'h6000;
    ticks(2);
    mispredict_valid = 1'b1; mispredict_pc = 64'h7000; mispredict_info = taken;
    tick();
    fence_valid = 1'b1; fence_kind = FENCE_KIND_VMA; fence_npc = 64'h6100;
    tick();
    trap_valid = 1'b1; trap_pc = 64'h4000; trap_reason = IF_PROT_CHANGED;
    expect_redirect(k + 5, 64'h4000, IF_PROT_CHANGED, no_info());
    tick();
    check("abort_busy", 128'(fence_busy), 128'd0);
    sb_empty = 1'b1;
    ticks(8);

    // Trap arriving in ISSUE wins; the fence redirect is dropped.
    k = cyc;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_I; fence_npc = 64'h6200;
    ticks(3);
    trap_valid = 1'b1; trap_pc = 64'h4400; trap_reason = IF_PROT_CHANGED;
    expect_redirect(k + 4, 64'h4400, IF_PROT_CHANGED, no_info());
    ticks(6);

    // Reset mid-DRAIN: outputs clear, no redirect, then a normal fence.
    sb_empty = 1'b0;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_VMA; fence_npc = 64'h5500;
    ticks(2);
    check("drain_busy_pre_reset", 128'(fence_busy), 128'd1);
    rst = 1'b1;
    tick();
    check("rst_busy", 128'(fence_busy), 128'd0);
    check("rst_valid", 128'(redirect_valid), 128'd0);
    rst = 1'b0;
    sb_empty = 1'b1;
    ticks(6);
    k = cyc;
    fence_valid = 1'b1; fence_kind = FENCE_KIND_I; fence_npc = 64'h5000;
    expect_redirect(k + 4, 64'h5000, IF_FENCE_I, no_info());
    ticks(8);

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
